// File: rtl/axi_nport_bridge.sv
// axi_nport_bridge: round-robin arbiter of N request clients
// onto one AXI master, one read or write burst in flight.
module axi_nport_bridge #(
  parameter int NUM_PORTS = 2,
  parameter int LEN_W     = 8,
  parameter int ID_W      = 4
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [NUM_PORTS-1:0]       req_valid,
  output logic [NUM_PORTS-1:0]       req_ready,
  input  logic [NUM_PORTS-1:0]       req_write,
  input  logic [NUM_PORTS*32-1:0]    req_addr,
  input  logic [NUM_PORTS*LEN_W-1:0] req_len,
  input  logic [NUM_PORTS*3-1:0]     req_size,
  input  logic [NUM_PORTS*32-1:0]    wr_data,
  input  logic [NUM_PORTS*4-1:0]     wr_strb,
  output logic [NUM_PORTS-1:0]       wr_beat,
  output logic [31:0]                rd_data,
  output logic [NUM_PORTS-1:0]       rd_valid,
  output logic                       rd_last,
  output logic [NUM_PORTS-1:0]       done,
  output logic [NUM_PORTS-1:0]       err,
  output logic [ID_W-1:0]            arid,
  output logic [31:0]                araddr,
  output logic [LEN_W-1:0]           arlen,
  output logic [2:0]                 arsize,
  output logic [1:0]                 arburst,
  output logic                       arvalid,
  input  logic                       arready,
  input  logic [ID_W-1:0]            rid,
  input  logic [31:0]                rdata,
  input  logic [1:0]                 rresp,
  input  logic                       rlast,
  input  logic                       rvalid,
  output logic                       rready,
  output logic [ID_W-1:0]            awid,
  output logic [31:0]                awaddr,
  output logic [LEN_W-1:0]           awlen,
  output logic [2:0]                 awsize,
  output logic [1:0]                 awburst,
  output logic                       awvalid,
  input  logic                       awready,
  output logic [ID_W-1:0]            wid,
  output logic [31:0]                wdata,
  output logic [3:0]                 wstrb,
  output logic                       wlast,
  output logic                       wvalid,
  input  logic                       wready,
  input  logic [ID_W-1:0]            bid,
  input  logic [1:0]                 bresp,
  input  logic                       bvalid,
  output logic                       bready
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_DONE
  } state_t;

  state_t               state;
  logic [PW-1:0]        ptr;
  logic [PW-1:0]        gnt;
  logic [PW-1:0]        pick;
  logic [PW-1:0]        scan;
  logic                 found;
  logic                 run;
  logic                 err_q;
  logic [31:0]          cap_addr;
  logic [LEN_W-1:0]     cap_len;
  logic [2:0]           cap_size;
  logic [LEN_W-1:0]     beat_cnt;
  logic [ID_W-1:0]      gid;
  logic [NUM_PORTS-1:0] gnt_oh;

  assign gid    = ID_W'(gnt);
  assign gnt_oh = NUM_PORTS'(1) << gnt;

  assign arid    = gid;
  assign araddr  = cap_addr;
  assign arlen   = cap_len;
  assign arsize  = cap_size;
  assign arburst = 2'b01;
  assign awid    = gid;
  assign awaddr  = cap_addr;
  assign awlen   = cap_len;
  assign awsize  = cap_size;
  assign awburst = 2'b01;
  assign wid     = gid;

  // Round-robin scan starting one past the last served port
  always_comb begin
    found = 1'b0;
    pick  = '0;
    scan  = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      scan = PW'((int'(ptr) + i) % NUM_PORTS);
      if (!found && req_valid[scan]) begin
        found = 1'b1;
        pick  = scan;
      end
    end
  end

  // Client and AXI strobes decoded from the current state
  always_comb begin
    req_ready = '0;
    wr_beat   = '0;
    rd_valid  = '0;
    rd_data   = '0;
    rd_last   = 1'b0;
    done      = '0;
    err       = '0;
    arvalid   = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    wdata     = '0;
    wstrb     = '0;
    wlast     = 1'b0;
    rready    = 1'b0;
    bready    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (run && found)
          req_ready = NUM_PORTS'(1) << pick;
      end
      S_AR: arvalid = 1'b1;
      S_R: begin
        rready = 1'b1;
        if (rvalid) begin
          rd_valid = gnt_oh;
          rd_data  = rdata;
          rd_last  = rlast;
        end
      end
      S_AW: awvalid = 1'b1;
      S_W: begin
        wvalid = 1'b1;
        wdata  = wr_data[gnt*32 +: 32];
        wstrb  = wr_strb[gnt*4 +: 4];
        wlast  = (beat_cnt == cap_len);
        if (wready)
          wr_beat = gnt_oh;
      end
      S_B: bready = 1'b1;
      S_DONE: begin
        done = gnt_oh;
        err  = err_q ? gnt_oh : '0;
      end
      default: ;
    endcase
  end

  // Transaction sequencer; run holds off grants for a cycle after reset
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= S_IDLE;
      ptr      <= PW'(NUM_PORTS - 1);
      gnt      <= '0;
      run      <= 1'b0;
      err_q    <= 1'b0;
      cap_addr <= '0;
      cap_len  <= '0;
      cap_size <= '0;
      beat_cnt <= '0;
    end else begin
      run <= 1'b1;
      unique case (state)
        S_IDLE: begin
          if (run && found) begin
            gnt      <= pick;
            cap_addr <= req_addr[pick*32 +: 32];
            cap_len  <= req_len[pick*LEN_W +: LEN_W];
            cap_size <= req_size[pick*3 +: 3];
            state    <= req_write[pick] ? S_AW : S_AR;
          end
        end
        S_AR: if (arready) state <= S_R;
        S_R: begin
          if (rvalid) begin
            if (rresp != 2'b00 || rid != gid)
              err_q <= 1'b1;
            if (rlast)
              state <= S_DONE;
          end
        end
        S_AW: if (awready) state <= S_W;
        S_W: begin
          if (wready) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == cap_len)
              state <= S_B;
          end
        end
        S_B: begin
          if (bvalid) begin
            if (bresp != 2'b00 || bid != gid)
              err_q <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          ptr      <= gnt;
          err_q    <= 1'b0;
          beat_cnt <= '0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_nport_bridge.sv
// tb_axi_nport_bridge: random clients and a reactive AXI slave
// checked against a transaction-level model of the bridge.
module tb_axi_nport_bridge;

  localparam int NP = 3;
  localparam int LW = 8;
  localparam int IW = 4;
  localparam int NTX = 60;

  logic aclk = 1'b0;
  logic aresetn;
  logic [NP-1:0] req_valid, req_ready, req_write;
  logic [NP-1:0] wr_beat, rd_valid, done, err;
  logic [NP*32-1:0] req_addr, wr_data;
  logic [NP*LW-1:0] req_len;
  logic [NP*3-1:0] req_size;
  logic [NP*4-1:0] wr_strb;
  logic [31:0] rd_data;
  logic rd_last;
  logic [IW-1:0] arid, rid, awid, wid, bid;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [LW-1:0] arlen, awlen;
  logic [2:0] arsize, awsize;
  logic [1:0] arburst, awburst, rresp, bresp;
  logic arvalid, arready, rlast, rvalid, rready;
  logic awvalid, awready;
  logic [3:0] wstrb;
  logic wlast, wvalid, wready, bvalid, bready;

  axi_nport_bridge #(
    .NUM_PORTS(NP), .LEN_W(LW), .ID_W(IW)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_len(req_len), .req_size(req_size),
    .wr_data(wr_data), .wr_strb(wr_strb),
    .wr_beat(wr_beat), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_last(rd_last),
    .done(done), .err(err),
    .arid(arid), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb),
    .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid),
    .bready(bready)
  );

  always #5 aclk = ~aclk;

  int checks, errors, cyc, idle_ok, created, lim;
  int ptr, g, acc_cyc, sbeat, stall, grants;
  bit act, adone, ddone, rdone, eerr, gen_on;
  bit pend[NP];
  bit wq[NP];
  logic [31:0] addr_q[NP];
  logic [LW-1:0] len_q[NP];
  logic [2:0] size_q[NP];
  logic [31:0] dat[NP][16];
  logic [3:0] stb[NP][16];
  int cbeat[NP];

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d got %0h exp %0h",
               tag, cyc, got, exp);
    end
  endtask

  function automatic logic [NP-1:0] onehot(input int i);
    logic [NP-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int arb(input logic [NP-1:0] v);
    for (int i = 1; i <= NP; i++) begin
      int k;
      k = (ptr + i) % NP;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  function automatic bit anypend();
    for (int p = 0; p < NP; p++)
      if (pend[p]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic newreq(input int p, input bit force_wr);
    pend[p] = 1'b1;
    wq[p] = force_wr ? 1'b1 : 1'($urandom_range(0, 1));
    addr_q[p] = $urandom & 32'hffff_fffc;
    if (force_wr)
      len_q[p] = 8'd7;
    else if ($urandom_range(0, 4) == 0)
      len_q[p] = 8'd0;
    else
      len_q[p] = LW'($urandom_range(0, 15));
    size_q[p] = 3'($urandom_range(0, 2));
    for (int b = 0; b < 16; b++) begin
      dat[p][b] = $urandom;
      stb[p][b] = 4'($urandom);
    end
    created++;
  endtask

  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      int cb;
      if (gen_on && created < lim && !pend[p] &&
          !(act && g == p) && $urandom_range(0, 3) == 0)
        newreq(p, 1'b0);
      cb = (cbeat[p] > 15) ? 15 : cbeat[p];
      req_valid[p] = pend[p] && ($urandom_range(0, 7) != 0);
      req_write[p] = wq[p];
      req_addr[p*32 +: 32] = addr_q[p];
      req_len[p*LW +: LW] = len_q[p];
      req_size[p*3 +: 3] = size_q[p];
      wr_data[p*32 +: 32] = dat[p][cb];
      wr_strb[p*4 +: 4] = stb[p][cb];
    end
    arready = ($urandom_range(0, 3) != 0);
    awready = ($urandom_range(0, 3) != 0);
    wready = ($urandom_range(0, 2) != 0);
    if (stall > 0) begin
      arready = 1'b0;
      awready = 1'b0;
      wready = 1'b0;
      stall--;
    end else if ($urandom_range(0, 24) == 0) begin
      stall = 5;
    end
    rvalid = 1'b0; rdata = '0; rresp = '0;
    rlast = 1'b0; rid = '0;
    bvalid = 1'b0; bresp = '0; bid = '0;
    if (act && adone && !ddone && !wq[g] &&
        $urandom_range(0, 2) != 0) begin
      rvalid = 1'b1;
      rdata = $urandom;
      rresp = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00;
      rid = ($urandom_range(0, 15) == 0) ? IW'(g + 1) : IW'(g);
      rlast = (sbeat == int'(len_q[g]));
    end
    if (act && ddone && !rdone && wq[g] &&
        $urandom_range(0, 1) == 0) begin
      bvalid = 1'b1;
      bresp = ($urandom_range(0, 4) == 0) ?
              2'($urandom_range(2, 3)) : 2'b00;
      bid = ($urandom_range(0, 9) == 0) ? IW'(g + 2) : IW'(g);
    end
  endtask

  task automatic observe();
    int e;
    logic [NP-1:0] em;
    bit dchk;
    dchk = 1'b0;
    if (!act && cyc >= idle_ok) begin
      e = arb(req_valid);
      em = '0;
      if (e >= 0) em[e] = 1'b1;
      chk("grant", req_ready, em);
      if (e >= 0) begin
        act = 1'b1; g = e; acc_cyc = cyc;
        adone = 0; ddone = 0; rdone = 0;
        sbeat = 0; eerr = 0;
        pend[e] = 1'b0; cbeat[e] = 0;
      end
    end else begin
      chk("rdy_busy", req_ready, '0);
    end
    if (!act || cyc == acc_cyc)
      chk("idle_axi",
          {arvalid, awvalid, wvalid, rready, bready}, '0);
    if (act && cyc > acc_cyc) begin
      if (cyc == acc_cyc + 1)
        chk("ax_lat", wq[g] ? awvalid : arvalid, 1);
      if (!adone) begin
        if (wq[g]) begin
          chk("awvalid", awvalid, 1);
          chk("arvalid0", arvalid, 0);
          chk("awaddr", awaddr, addr_q[g]);
          chk("awlen", awlen, len_q[g]);
          chk("awsize", awsize, size_q[g]);
          chk("awburst", awburst, 2'b01);
          chk("awid", awid, IW'(g));
          if (awready) adone = 1'b1;
        end else begin
          chk("arvalid", arvalid, 1);
          chk("awvalid0", awvalid, 0);
          chk("araddr", araddr, addr_q[g]);
          chk("arlen", arlen, len_q[g]);
          chk("arsize", arsize, size_q[g]);
          chk("arburst", arburst, 2'b01);
          chk("arid", arid, IW'(g));
          if (arready) adone = 1'b1;
        end
      end else if (!ddone) begin
        if (wq[g]) begin
          chk("wvalid", wvalid, 1);
          chk("wdata", wdata, dat[g][sbeat]);
          chk("wstrb", wstrb, stb[g][sbeat]);
          chk("wid", wid, IW'(g));
          chk("wlast", wlast, sbeat == int'(len_q[g]));
          if (wready) begin
            chk("wr_beat", wr_beat, onehot(g));
            sbeat++;
            if (sbeat > int'(len_q[g])) ddone = 1'b1;
          end else begin
            chk("wr_beat0", wr_beat, '0);
          end
        end else begin
          chk("rready", rready, 1);
          if (rvalid) begin
            chk("rd_valid", rd_valid, onehot(g));
            chk("rd_data", rd_data, rdata);
            chk("rd_last", rd_last, rlast);
            if (rresp != 2'b00 || rid != IW'(g)) eerr = 1'b1;
            sbeat++;
            if (rlast) begin
              ddone = 1'b1;
              rdone = 1'b1;
            end
          end else begin
            chk("rd_valid0", rd_valid, '0);
          end
        end
      end else if (!rdone) begin
        chk("bready", bready, 1);
        chk("wvalid0", wvalid, 0);
        if (bvalid) begin
          if (bresp != 2'b00 || bid != IW'(g)) eerr = 1'b1;
          rdone = 1'b1;
        end
      end else begin
        dchk = 1'b1;
        chk("done", done, onehot(g));
        chk("err", err, eerr ? onehot(g) : '0);
        act = 1'b0;
        ptr = g;
        idle_ok = cyc + 1;
        grants++;
      end
    end
    if (!dchk) chk("done0", done, '0);
    for (int p = 0; p < NP; p++)
      if (wr_beat[p]) cbeat[p]++;
  endtask

  task automatic step(input bit rel);
    @(posedge aclk);
    cyc++;
    #1;
    if (rel) begin
      aresetn = 1'b1;
      idle_ok = cyc + 1;
    end
    drive();
    @(negedge aclk);
    observe();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req_ready"}, req_ready, '0);
    chk({tag, "_wr_beat"}, wr_beat, '0);
    chk({tag, "_rd_valid"}, rd_valid, '0);
    chk({tag, "_done"}, done, '0);
    chk({tag, "_err"}, err, '0);
    chk({tag, "_arvalid"}, arvalid, 0);
    chk({tag, "_awvalid"}, awvalid, 0);
    chk({tag, "_wvalid"}, wvalid, 0);
    chk({tag, "_rready"}, rready, 0);
    chk({tag, "_bready"}, bready, 0);
  endtask

  initial begin
    int gbase;
    checks = 0; errors = 0; cyc = 0;
    idle_ok = 1 << 30; created = 0; lim = NTX;
    ptr = NP - 1; g = 0; act = 0; gen_on = 0;
    stall = 0; grants = 0;
    for (int p = 0; p < NP; p++) begin
      pend[p] = 0; wq[p] = 0; addr_q[p] = '0;
      len_q[p] = '0; size_q[p] = '0; cbeat[p] = 0;
      for (int b = 0; b < 16; b++) begin
        dat[p][b] = '0;
        stb[p][b] = '0;
      end
    end
    aresetn = 1'b1;
    drive();
    #1 aresetn = 1'b0;
    #1 chk_zero("rst");
    repeat (3) step(1'b0);
    step(1'b1);
    gen_on = 1'b1;
    for (int n = 0; n < 30000; n++) begin
      if (created >= lim && !act && !anypend()) break;
      step(1'b0);
    end
    chk("rnd_drain", {act, anypend()}, 2'b00);

    gen_on = 1'b0;
    newreq(0, 1'b1);
    for (int n = 0; n < 3000; n++) begin
      if (act && g == 0 && adone && !ddone && sbeat >= 2)
        break;
      step(1'b0);
    end
    chk("w_reached", {act, adone, ddone}, 3'b110);
    @(posedge aclk);
    cyc++;
    #2 aresetn = 1'b0;
    #1 chk_zero("rst_mid");
    act = 1'b0;
    ptr = NP - 1;
    idle_ok = 1 << 30;
    for (int p = 0; p < NP; p++) begin
      pend[p] = 1'b0;
      cbeat[p] = 0;
    end
    newreq(1, 1'b0);
    repeat (2) step(1'b0);
    step(1'b1);
    gbase = grants;
    lim = created + 4;
    gen_on = 1'b1;
    for (int n = 0; n < 5000; n++) begin
      if (created >= lim && !act && !anypend()) break;
      step(1'b0);
    end
    chk("post_drain", {act, anypend()}, 2'b00);
    chk("post_grants", grants - gbase, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
